sid_filter_sched: RTL and testbench

Time-multiplexes one shared filter/output-stage datapath between SID #1 and SID #2. On each audio sample tick it snapshots both chips' filter inputs and issues them to the datapath in turn over a valid/ready request. It keeps each chip's filter state variables between samples and assembles the results into one stereo audio word: left is SID #1, right is SID #2.

---
 rtl/sid_filter_sched.sv | 176 +++++++++++++++++
 tb/tb_sid_filter_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_filter_sched.sv
// sid_filter_sched: time-shares one filter/output datapath between SID #1/#2.
// Ports: tick/dual/job*_i in, filter_o/valid/ready req, res_* in, audio_o out.
package sid_pkg;
  typedef logic signed [23:0] s24_t;

  typedef struct packed {
    logic [15:0] vhp;
    logic [15:0] vbp;
    logic [15:0] vlp;
  } filter_v_t;

  typedef struct packed {
    logic [10:0] fc;
    logic [3:0]  res;
    logic [3:0]  filt;
    logic [3:0]  mode;
    logic [3:0]  vol;
    logic [15:0] v1;
    logic [15:0] v2;
    logic [15:0] v3;
    filter_v_t   state;
  } filter_i_t;

  typedef struct packed {
    s24_t left;
    s24_t right;
  } audio_t;
endpackage

module sid_filter_sched
  import sid_pkg::*;
#(
  parameter int unsigned MAX_LAT = 15
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tick,
  input  logic      dual,
  input  filter_i_t job0_i,
  input  filter_i_t job1_i,
  output filter_i_t filter_o,
  output logic      filter_valid,
  input  logic      filter_ready,
  input  logic      res_valid,
  input  filter_v_t res_state,
  input  s24_t      res_audio,
  output audio_t    audio_o,
  output logic      audio_valid,
  output logic      busy,
  output logic      overrun,
  output logic      timeout
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    DONE
  } state_t;

  state_t    state;
  state_t    st_n;
  filter_i_t job0_q;
  filter_i_t job1_q;
  logic      dual_q;
  filter_v_t st0;
  filter_v_t st1;
  s24_t      smp0;
  s24_t      smp1;
  s24_t      smp0_n;
  s24_t      smp1_n;
  logic [7:0] cnt;
  logic      in_wait;
  logic      expire;

  assign in_wait = (state == WAIT0) || (state == WAIT1);
  assign expire  = in_wait && !res_valid
                && (cnt == 8'(MAX_LAT - 1));

  // sample values as they will be after this edge, so
  // audio_o can be presented in the DONE cycle itself
  assign smp0_n = (state == WAIT0 && res_valid)
                ? res_audio : smp0;
  assign smp1_n = (state == WAIT1 && res_valid)
                ? res_audio : smp1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= st_n;
  end

  always_comb begin
    st_n = state;
    unique case (state)
      IDLE:   if (tick) st_n = ISSUE0;
      ISSUE0: if (filter_ready) st_n = WAIT0;
      WAIT0:
        if (res_valid || expire)
          st_n = dual_q ? ISSUE1 : DONE;
      ISSUE1: if (filter_ready) st_n = WAIT1;
      WAIT1:
        if (res_valid || expire) st_n = DONE;
      DONE:   st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    filter_o     = '0;
    filter_valid = 1'b0;
    unique case (1'b1)
      state == ISSUE0: begin
        filter_o       = job0_q;
        filter_o.state = st0;
        filter_valid   = 1'b1;
      end
      state == ISSUE1: begin
        filter_o       = job1_q;
        filter_o.state = st1;
        filter_valid   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job0_q      <= '0;
      job1_q      <= '0;
      dual_q      <= 1'b0;
      st0         <= '0;
      st1         <= '0;
      smp0        <= '0;
      smp1        <= '0;
      cnt         <= '0;
      audio_o     <= '0;
      audio_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (state == IDLE && tick) begin
        job0_q <= job0_i;
        job1_q <= job1_i;
        dual_q <= dual;
      end

      if (!in_wait)
        cnt <= '0;
      else if (!res_valid)
        cnt <= cnt + 8'd1;

      if (state == WAIT0 && res_valid) begin
        st0  <= res_state;
        smp0 <= res_audio;
      end
      if (state == WAIT1 && res_valid) begin
        st1  <= res_state;
        smp1 <= res_audio;
      end

      if (st_n == DONE) begin
        audio_o.left  <= smp0_n;
        audio_o.right <= dual_q ? smp1_n : smp0_n;
      end

      audio_valid <= (st_n == DONE);
      busy        <= (st_n != IDLE);
      overrun     <= tick && (state != IDLE);
      timeout     <= expire;
    end
  end

endmodule

// File: tb/tb_sid_filter_sched.sv
// tb_sid_filter_sched: directed bench for sid_filter_sched.
// Drives tick/jobs/results per cycle and checks outputs inline.
module tb_sid_filter_sched;
  import sid_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      tick;
  logic      dual;
  filter_i_t job0_i;
  filter_i_t job1_i;
  filter_i_t filter_o;
  logic      filter_valid;
  logic      filter_ready;
  logic      res_valid;
  filter_v_t res_state;
  s24_t      res_audio;
  audio_t    audio_o;
  logic      audio_valid;
  logic      busy;
  logic      overrun;
  logic      timeout;

  int n_cmp;
  int n_err;

  filter_i_t J0, J1, J2, J3, e;
  filter_v_t S0, S0b, S1b, S0c, S0d, S1d, S0e;

  sid_filter_sched #(.MAX_LAT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .dual         (dual),
    .job0_i       (job0_i),
    .job1_i       (job1_i),
    .filter_o     (filter_o),
    .filter_valid (filter_valid),
    .filter_ready (filter_ready),
    .res_valid    (res_valid),
    .res_state    (res_state),
    .res_audio    (res_audio),
    .audio_o      (audio_o),
    .audio_valid  (audio_valid),
    .busy         (busy),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic respond(input s24_t a, input filter_v_t s);
    res_valid = 1'b1;
    res_audio = a;
    res_state = s;
  endtask

  task automatic test_reset;
    repeat (2) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (filter_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_fvalid got %b exp 0", filter_valid); end
    n_cmp++; if (audio_valid !== 1'b0) begin n_err++;
      $display("FAIL rst_avalid got %b exp 0", audio_valid); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++;
      $display("FAIL rst_overrun got %b exp 0", overrun); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++;
      $display("FAIL rst_timeout got %b exp 0", timeout); end
    n_cmp++; if (audio_o !== '0) begin n_err++;
      $display("FAIL rst_audio got %h exp 0", audio_o); end
    n_cmp++; if (filter_o !== '0) begin n_err++;
      $display("FAIL rst_filter_o got %h exp 0", filter_o); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic;
    dual = 1'b1; filter_ready = 1'b1;
    job0_i = J0; job1_i = J1; tick = 1'b1;
    step(); tick = 1'b0;
    e = J0; e.state = '0;
    n_cmp++; if (filter_valid !== 1'b1) begin n_err++;
      $display("FAIL basic_fv0 got %b exp 1", filter_valid); end
    n_cmp++; if (filter_o !== e) begin n_err++;
      $display("FAIL basic_fo0 got %h exp %h", filter_o, e); end
    n_cmp++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL basic_busy1 got %b exp 1", busy); end
    step();
    n_cmp++; if (filter_valid !== 1'b0) begin n_err++;
      $display("FAIL basic_fvw0 got %b exp 0", filter_valid); end
    respond(24'h000100, S0);
    step(); res_valid = 1'b0;
    e = J1; e.state = '0;
    n_cmp++; if (filter_o !== e || filter_valid !== 1'b1) begin
      n_err++;
      $display("FAIL basic_fo1 got %h/%b exp %h/1",
               filter_o, filter_valid, e); end
    step();
    n_cmp++; if (audio_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_t4 got av=%b busy=%b exp 0/1",
               audio_valid, busy); end
    respond(24'h000200, '0);
    step(); res_valid = 1'b0;
    n_cmp++; if (audio_valid !== 1'b1) begin n_err++;
      $display("FAIL basic_av got %b exp 1", audio_valid); end
    n_cmp++; if (audio_o.left !== 24'h000100
              || audio_o.right !== 24'h000200) begin n_err++;
      $display("FAIL basic_audio got %h exp 000100000200",
               audio_o); end
    n_cmp++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL basic_busy5 got %b exp 1", busy); end
    step();
    n_cmp++; if (audio_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_t6 got av=%b busy=%b exp 0/0",
               audio_valid, busy); end
  endtask

  task automatic test_persist;
    job0_i = J2; job1_i = J3; tick = 1'b1;
    step(); tick = 1'b0;
    e = J2; e.state = S0;
    n_cmp++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL persist_accept got %b exp 1", busy); end
    n_cmp++; if (filter_o !== e) begin n_err++;
      $display("FAIL persist_st0 got %h exp %h", filter_o, e); end
    step(); respond(24'h000300, S0b);
    step(); res_valid = 1'b0;
    e = J3; e.state = '0;
    n_cmp++; if (filter_o !== e) begin n_err++;
      $display("FAIL persist_st1 got %h exp %h", filter_o, e); end
    step(); respond(24'h000400, S1b);
    step(); res_valid = 1'b0;
    n_cmp++; if (audio_valid !== 1'b1
              || audio_o !== {24'h000300, 24'h000400}) begin n_err++;
      $display("FAIL persist_audio got %b/%h exp 1/000300000400",
               audio_valid, audio_o); end
    step();
  endtask

  task automatic test_backpressure;
    filter_ready = 1'b0; job0_i = J0; job1_i = J1; tick = 1'b1;
    step(); tick = 1'b0;
    e = J0; e.state = S0b;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (filter_valid !== 1'b1 || filter_o !== e) begin
        n_err++;
        $display("FAIL bp_hold%0d got %b/%h exp 1/%h",
                 i, filter_valid, filter_o, e); end
      job0_i.fc = 11'($urandom);
      job0_i.v1 = 16'($urandom);
      job0_i.vol = 4'(i + 7);
      step();
    end
    filter_ready = 1'b1;
    n_cmp++; if (filter_o !== e) begin n_err++;
      $display("FAIL bp_last got %h exp %h", filter_o, e); end
    step();
    n_cmp++; if (filter_valid !== 1'b0) begin n_err++;
      $display("FAIL bp_wait got %b exp 0", filter_valid); end
    respond(24'h000500, S0b);
    step(); res_valid = 1'b0;
    e = J1; e.state = S1b;
    n_cmp++; if (filter_o !== e) begin n_err++;
      $display("FAIL bp_fo1 got %h exp %h", filter_o, e); end
    step(); respond(24'h000600, S1b);
    step(); res_valid = 1'b0;
    n_cmp++; if (audio_o !== {24'h000500, 24'h000600}) begin
      n_err++;
      $display("FAIL bp_audio got %h exp 000500000600", audio_o); end
    step();
  endtask

  task automatic test_timeout;
    job0_i = J0; job1_i = J1; tick = 1'b1;
    step(); tick = 1'b0;
    step(); respond(24'h000700, S0c);
    step(); res_valid = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (timeout !== 1'b0) begin n_err++;
        $display("FAIL to_early%0d got %b exp 0", k, timeout); end
      step();
    end
    n_cmp++; if (timeout !== 1'b1 || audio_valid !== 1'b1) begin
      n_err++;
      $display("FAIL to_pulse got to=%b av=%b exp 1/1",
               timeout, audio_valid); end
    n_cmp++; if (audio_o !== {24'h000700, 24'h000600}) begin
      n_err++;
      $display("FAIL to_audio got %h exp 000700000600", audio_o); end
    respond(24'h000BAD, S0);
    step(); res_valid = 1'b0;
    n_cmp++; if (timeout !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL to_after got to=%b busy=%b exp 0/0",
               timeout, busy); end
  endtask

  task automatic test_overrun;
    job0_i = J0; job1_i = J1; tick = 1'b1;
    step(); tick = 1'b0;
    step(); tick = 1'b1; respond(24'h000800, S0d);
    step(); tick = 1'b0; res_valid = 1'b0;
    e = J1; e.state = S1b;
    n_cmp++; if (overrun !== 1'b1) begin n_err++;
      $display("FAIL ov_pulse got %b exp 1", overrun); end
    n_cmp++; if (filter_valid !== 1'b1 || filter_o !== e) begin
      n_err++;
      $display("FAIL ov_st1 got %b/%h exp 1/%h",
               filter_valid, filter_o, e); end
    step();
    n_cmp++; if (overrun !== 1'b0) begin n_err++;
      $display("FAIL ov_clear got %b exp 0", overrun); end
    respond(24'h000900, S1d);
    step(); res_valid = 1'b0;
    n_cmp++; if (audio_valid !== 1'b1
              || audio_o !== {24'h000800, 24'h000900}) begin n_err++;
      $display("FAIL ov_audio got %b/%h exp 1/000800000900",
               audio_valid, audio_o); end
    tick = 1'b1;
    step(); tick = 1'b0;
    n_cmp++; if (overrun !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ov_done got ov=%b busy=%b exp 1/0",
               overrun, busy); end
    step();
    n_cmp++; if (overrun !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ov_idle got ov=%b busy=%b exp 0/0",
               overrun, busy); end
  endtask

  task automatic test_mono;
    dual = 1'b0; job0_i = J2; job1_i = J3; tick = 1'b1;
    step(); tick = 1'b0; dual = 1'b1;
    e = J2; e.state = S0d;
    n_cmp++; if (filter_o !== e) begin n_err++;
      $display("FAIL mono_fo got %h exp %h", filter_o, e); end
    step(); respond(24'h7FFFFF, S0e);
    n_cmp++; if (filter_valid !== 1'b0) begin n_err++;
      $display("FAIL mono_fv2 got %b exp 0", filter_valid); end
    step(); res_valid = 1'b0;
    n_cmp++; if (audio_valid !== 1'b1 || filter_valid !== 1'b0)
    begin n_err++;
      $display("FAIL mono_t3 got av=%b fv=%b exp 1/0",
               audio_valid, filter_valid); end
    n_cmp++; if (audio_o !== {24'h7FFFFF, 24'h7FFFFF}) begin
      n_err++;
      $display("FAIL mono_audio got %h exp 7fffff7fffff", audio_o); end
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL mono_idle got %b exp 0", busy); end
    tick = 1'b1;
    step(); tick = 1'b0;
    e = J2; e.state = S0e;
    n_cmp++; if (busy !== 1'b1 || filter_o !== e) begin n_err++;
      $display("FAIL mono_next got %b/%h exp 1/%h",
               busy, filter_o, e); end
    step(); respond(24'h000A00, S0e);
    step(); res_valid = 1'b0;
    e = J3; e.state = S1d;
    n_cmp++; if (filter_o !== e) begin n_err++;
      $display("FAIL mono_st1 got %h exp %h", filter_o, e); end
    step(); respond(24'h000B00, S1d);
    step(); res_valid = 1'b0;
    n_cmp++; if (audio_o !== {24'h000A00, 24'h000B00}) begin
      n_err++;
      $display("FAIL mono_dual got %h exp 000a00000b00", audio_o); end
    step();
  endtask

  task automatic test_reset_mid;
    dual = 1'b1; job0_i = J0; job1_i = J1; tick = 1'b1;
    step(); tick = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || audio_o !== '0) begin n_err++;
      $display("FAIL rm_async got busy=%b audio=%h exp 0/0",
               busy, audio_o); end
    n_cmp++; if (filter_valid !== 1'b0 || filter_o !== '0
              || audio_valid !== 1'b0) begin n_err++;
      $display("FAIL rm_outs got fv=%b fo=%h av=%b exp 0",
               filter_valid, filter_o, audio_valid); end
    step(); step();
    rst_n = 1'b1;
    respond(24'h000C00, S0d);
    step(); res_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0 || audio_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rm_late got busy=%b av=%b exp 0/0",
               busy, audio_valid); end
    tick = 1'b1;
    step(); tick = 1'b0;
    e = J0; e.state = '0;
    n_cmp++; if (filter_o !== e) begin n_err++;
      $display("FAIL rm_fo0 got %h exp %h", filter_o, e); end
    step(); respond(24'h000D00, S0);
    step(); res_valid = 1'b0;
    e = J1; e.state = '0;
    n_cmp++; if (filter_o !== e) begin n_err++;
      $display("FAIL rm_fo1 got %h exp %h", filter_o, e); end
    step(); respond(24'h000E00, S0);
    step(); res_valid = 1'b0;
    n_cmp++; if (audio_valid !== 1'b1
              || audio_o !== {24'h000D00, 24'h000E00}) begin n_err++;
      $display("FAIL rm_audio got %b/%h exp 1/000d00000e00",
               audio_valid, audio_o); end
    step();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; tick = 1'b0; dual = 1'b0;
    filter_ready = 1'b0; res_valid = 1'b0;
    res_state = '0; res_audio = '0;
    J0 = '{fc:11'h123, res:4'h5, filt:4'h3, mode:4'h1, vol:4'hF,
           v1:16'h1111, v2:16'h2222, v3:16'h3333,
           state:'{vhp:16'hDEAD, vbp:16'hBEEF, vlp:16'hCAFE}};
    J1 = '{fc:11'h456, res:4'hA, filt:4'h6, mode:4'h2, vol:4'h8,
           v1:16'h4444, v2:16'h5555, v3:16'h6666,
           state:'{vhp:16'hFFFF, vbp:16'h0F0F, vlp:16'hF0F0}};
    J2 = '{fc:11'h7AB, res:4'h1, filt:4'h7, mode:4'h4, vol:4'h3,
           v1:16'h7777, v2:16'h8888, v3:16'h9999,
           state:'{vhp:16'h1357, vbp:16'h2468, vlp:16'h9ABC}};
    J3 = '{fc:11'h0CD, res:4'hE, filt:4'h0, mode:4'h7, vol:4'h9,
           v1:16'hAAAA, v2:16'hBBBB, v3:16'hCCCC,
           state:'{vhp:16'h5A5A, vbp:16'hA5A5, vlp:16'h3C3C}};
    S0  = '{vhp:16'h0011, vbp:16'h0022, vlp:16'h1234};
    S0b = '{vhp:16'h0101, vbp:16'h0202, vlp:16'h0303};
    S1b = '{vhp:16'h1010, vbp:16'h2020, vlp:16'h5678};
    S0c = '{vhp:16'h0C0C, vbp:16'h0D0D, vlp:16'h0E0E};
    S0d = '{vhp:16'h4321, vbp:16'h8765, vlp:16'h0FED};
    S1d = '{vhp:16'h7654, vbp:16'h3210, vlp:16'hBA98};
    S0e = '{vhp:16'h1111, vbp:16'h2222, vlp:16'h3333};
    e = '0;
    job0_i = '0; job1_i = '0;
    test_reset();
    test_basic();
    test_persist();
    test_backpressure();
    test_timeout();
    test_overrun();
    test_mono();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
